i2s_playback_axil_regs: RTL and testbench
=========================================

Name: i2s_playback_axil_regs

Overview:
- AXI4-Lite slave (responder) register bank for the i2s_playback IP. It is the S00_AXI endpoint that a master BFM drives.
- Holds four 32-bit read/write registers at offsets 0x0, 0x4, 0x8 and 0xC, and exports them to the I2S datapath.
- Emits a one-cycle write-commit pulse per register so the datapath can react to each fresh write, such as sample pushes or control changes.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; bits [3:2] select the register.

Ports:
- s00_axi_aclk  in  1  single clock for the whole block
- s00_axi_aresetn  in  1  asynchronous active-low reset
- s00_axi_awaddr  in  4  write address
- s00_axi_awprot  in  3  ignored
- s00_axi_awvalid  in  1  write address valid
- s00_axi_awready  out  1  write address ready
- s00_axi_wdata  in  32  write data
- s00_axi_wstrb  in  4  byte enables
- s00_axi_wvalid  in  1  write data valid
- s00_axi_wready  out  1  write data ready
- s00_axi_bresp  out  2  write response, always 2'b00
- s00_axi_bvalid  out  1  write response valid
- s00_axi_bready  in  1  write response ready
- s00_axi_araddr  in  4  read address
- s00_axi_arprot  in  3  ignored
- s00_axi_arvalid  in  1  read address valid
- s00_axi_arready  out  1  read address ready
- s00_axi_rdata  out  32  read data
- s00_axi_rresp  out  2  read response, always 2'b00
- s00_axi_rvalid  out  1  read data valid
- s00_axi_rready  in  1  read data ready
- reg0_out..reg3_out  out  32 each  current register contents, to the datapath
- reg_wr_pulse  out  4  bit k high for one cycle after register k is written

Behaviour:
- Reset:
  - Reset is asynchronous and active-low.
  - While s00_axi_aresetn=0: all READY/VALID outputs are 0, bresp/rresp=0, rdata=0, reg0..reg3=0, reg_wr_pulse=0.
  - Reset asserted mid-transaction aborts that transaction. No response is issued afterwards.
- Write accept:
  - s00_axi_awready and s00_axi_wready rise together for exactly one cycle.
  - Condition: awvalid=1, wvalid=1, bvalid=0, and both readys were low in the previous cycle.
  - AW without W, or W without AW, waits and is not accepted alone. A master may present them in any order or skew.
- Write commit:
  - Happens on the accept edge. Target register = awaddr[3:2].
  - Byte lane b is updated only if wstrb[b]=1. wstrb=0 leaves the register unchanged but still completes with OKAY.
  - The same edge sets bvalid=1 and reg_wr_pulse[awaddr[3:2]]=1. The pulse lasts one cycle.
- Write response:
  - bvalid holds at 1 until the edge where bready=1, then clears.
  - No new write is accepted while bvalid=1, so at most one write is outstanding.
  - Minimum write latency: accept cycle N, bvalid visible in cycle N+1.
- Read accept:
  - arready pulses for one cycle when arvalid=1, rvalid=0 and arready was 0 in the previous cycle.
  - On that edge, rdata is loaded with register araddr[3:2] and rvalid is set.
- Read response:
  - rvalid and rdata hold stable until the edge where rready=1.
  - No new read is accepted while rvalid=1.
- Read and write together:
  - The read and write channels are independent and may complete in the same cycle.
  - A read accepted on the same edge as a write to the same register returns the pre-write value.
- Address handling: awaddr[1:0] and araddr[1:0] are ignored. All four offsets respond; there is no SLVERR/DECERR.
- Throughput: one write per 2 cycles and one read per 2 cycles when bready/rready are held at 1.

Test Plan:
- Reset, then sequential AXI4-Lite writes 0x1, 0x2, 0x3, 0x4 to addresses 0x0/0x4/0x8/0xC, then four reads → rdata 0x1..0x4 in order, all bresp/rresp=00, reg_wr_pulse = 0001, 0010, 0100, 1000 in order, each one cycle wide.
- Write 0xFFFFFFFF to 0x4, then write 0x12345678 with wstrb=4'b0101 → reg1_out=0xFF34FF78, and a read of 0x4 returns 0xFF34FF78.
- AWVALID asserted 3 cycles before WVALID → no awready until WVALID is high, then awready and wready in the same cycle, and bvalid the next cycle.
- bready held low 5 cycles after a write → bvalid stays 1 for 5+ cycles; a second AW+W presented meanwhile gets no ready until one cycle after the B handshake.
- Same-edge read of 0x8 (old value 0x3) and write of 0xAA to 0x8 → rdata=0x3, a subsequent read returns 0xAA.
- Deassert aresetn while bvalid=1 and rvalid=1 → both drop immediately, reg0..reg3=0, and after release the first read of 0x0 returns 0x0.

Source files
------------

// File: rtl/i2s_playback_axil_regs.sv
// ---------------------------------------------------------------------------
// i2s_playback_axil_regs
//
// AXI4-Lite responder (S00_AXI) holding the four 32-bit control/data
// registers of the i2s_playback IP. Contents go straight out to the I2S
// datapath. A one-cycle commit pulse per register tells the datapath that a
// fresh write landed, for example a sample push or a control change.
//
// Ports
//   s00_axi_aclk / s00_axi_aresetn : clock, asynchronous active-low reset
//   s00_axi_aw* / s00_axi_w*       : write address / write data channels
//   s00_axi_b*                     : write response channel (always OKAY)
//   s00_axi_ar* / s00_axi_r*       : read address / read data channels
//                                    (always OKAY)
//   reg0_out .. reg3_out           : current register contents
//   reg_wr_pulse[k]                : high for one cycle after register k
//                                    is written
//
// Address bits [3:2] select the register. Bits [1:0] and the prot inputs are
// ignored. Every offset responds, so there is no error response.
// ---------------------------------------------------------------------------
module i2s_playback_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_aresetn,
  // write address channel
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  // write data channel
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  // write response channel
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  // read address channel
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  // read data channel
  output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
  // datapath side
  output logic [C_S_AXI_DATA_WIDTH-1:0]     reg0_out,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     reg1_out,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     reg2_out,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     reg3_out,
  output logic [3:0]                        reg_wr_pulse
);

  localparam int NUM_REGS = 4;
  localparam int STRB_W   = C_S_AXI_DATA_WIDTH / 8;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  // awready and wready always move together, so one flop drives both.
  logic                          wr_ready_q, wr_ready_d;
  logic                          bvalid_q,   bvalid_d;
  logic [3:0]                    wr_pulse_q, wr_pulse_d;
  logic                          arready_q,  arready_d;
  logic                          rvalid_q,   rvalid_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q,    rdata_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [C_S_AXI_DATA_WIDTH-1:0] regs_d [NUM_REGS];

  // Handshakes completing at the coming clock edge.
  logic       wr_fire;
  logic       rd_fire;
  logic [1:0] wr_idx;
  logic [1:0] rd_idx;

  assign wr_fire = wr_ready_q & s00_axi_awvalid & s00_axi_wvalid;
  assign rd_fire = arready_q & s00_axi_arvalid;
  assign wr_idx  = s00_axi_awaddr[3:2];
  assign rd_idx  = s00_axi_araddr[3:2];

  // Inputs that carry no meaning for this block.
  logic unused_inputs;
  assign unused_inputs = ^{s00_axi_awprot, s00_axi_arprot,
                           s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  // -------------------------------------------------------------------------
  // Write path
  // -------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ready_d = 1'b0;
    bvalid_d   = bvalid_q;
    wr_pulse_d = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      regs_d[k] = regs_q[k];
    end

    // Accept only a complete AW+W pair. The B slot counts as free when it is
    // draining this very cycle, which sustains one write every two cycles
    // while still never having two responses outstanding.
    if (s00_axi_awvalid && s00_axi_wvalid && !wr_ready_q &&
        (!bvalid_q || s00_axi_bready)) begin
      wr_ready_d = 1'b1;
    end

    if (bvalid_q && s00_axi_bready) begin
      bvalid_d = 1'b0;
    end

    if (wr_fire) begin
      bvalid_d           = 1'b1;
      wr_pulse_d[wr_idx] = 1'b1;
      for (int b = 0; b < STRB_W; b++) begin
        if (s00_axi_wstrb[b]) begin
          regs_d[wr_idx][8*b +: 8] = s00_axi_wdata[8*b +: 8];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read path
  // -------------------------------------------------------------------------
  // regs_q is sampled before this edge's write lands, so a read and a write to
  // the same register on one edge return the old value.
  always_comb begin
    arready_d = 1'b0;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;

    if (s00_axi_arvalid && !arready_q && (!rvalid_q || s00_axi_rready)) begin
      arready_d = 1'b1;
    end

    if (rvalid_q && s00_axi_rready) begin
      rvalid_d = 1'b0;
    end

    if (rd_fire) begin
      rvalid_d = 1'b1;
      rdata_d  = regs_q[rd_idx];
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      wr_ready_q <= 1'b0;
      bvalid_q   <= 1'b0;
      wr_pulse_q <= '0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      wr_ready_q <= wr_ready_d;
      bvalid_q   <= bvalid_d;
      wr_pulse_q <= wr_pulse_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
    end
  end

  // NOTE: this small array is a bank of architecturally visible registers
  // rather than a RAM, so it takes the reset like any other flop; a real
  // memory would be left unreset.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= regs_d[k];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign s00_axi_awready = wr_ready_q;
  assign s00_axi_wready  = wr_ready_q;
  assign s00_axi_bresp   = 2'b00;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_arready = arready_q;
  assign s00_axi_rdata   = rdata_q;
  assign s00_axi_rresp   = 2'b00;
  assign s00_axi_rvalid  = rvalid_q;

  assign reg0_out     = regs_q[0];
  assign reg1_out     = regs_q[1];
  assign reg2_out     = regs_q[2];
  assign reg3_out     = regs_q[3];
  assign reg_wr_pulse = wr_pulse_q;

endmodule

// File: tb/tb_i2s_playback_axil_regs.sv
// ---------------------------------------------------------------------------
// tb_i2s_playback_axil_regs
//
// Self-checking bench for i2s_playback_axil_regs. A passive monitor observes
// the AXI handshakes on the negative clock edge and keeps a transaction-level
// model (register array, pending B/R flags, expected read data, expected
// commit pulse). The same process compares every DUT output against that
// model each cycle. Directed sequences add literal expectations, and a
// randomized phase mixes reads and writes with random skew and back-pressure.
// ---------------------------------------------------------------------------
module tb_i2s_playback_axil_regs;

  logic        clk;
  logic        rst_n;
  logic [3:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] reg0_out, reg1_out, reg2_out, reg3_out;
  logic [3:0]  reg_wr_pulse;

  i2s_playback_axil_regs #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4)
  ) dut (
    .s00_axi_aclk   (clk),
    .s00_axi_aresetn(rst_n),
    .s00_axi_awaddr (awaddr),
    .s00_axi_awprot (awprot),
    .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready),
    .s00_axi_wdata  (wdata),
    .s00_axi_wstrb  (wstrb),
    .s00_axi_wvalid (wvalid),
    .s00_axi_wready (wready),
    .s00_axi_bresp  (bresp),
    .s00_axi_bvalid (bvalid),
    .s00_axi_bready (bready),
    .s00_axi_araddr (araddr),
    .s00_axi_arprot (arprot),
    .s00_axi_arvalid(arvalid),
    .s00_axi_arready(arready),
    .s00_axi_rdata  (rdata),
    .s00_axi_rresp  (rresp),
    .s00_axi_rvalid (rvalid),
    .s00_axi_rready (rready),
    .reg0_out       (reg0_out),
    .reg1_out       (reg1_out),
    .reg2_out       (reg2_out),
    .reg3_out       (reg3_out),
    .reg_wr_pulse   (reg_wr_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // -------------------------------------------------------------------------
  // Bookkeeping
  // -------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp,
               $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Transaction-level model + per-cycle compare
  // -------------------------------------------------------------------------
  logic [31:0] m_regs [4];
  logic        m_bpend;
  logic        m_rpend;
  logic [31:0] m_rdata;
  logic [3:0]  m_pulse;
  logic        prev_awready;
  logic        prev_arready;
  logic [3:0]  pulse_log [$];

  initial begin
    for (int k = 0; k < 4; k++) m_regs[k] = '0;
    m_bpend = 0; m_rpend = 0; m_rdata = '0; m_pulse = '0;
    prev_awready = 0; prev_arready = 0;
  end

  always @(negedge clk) begin
    logic [31:0] mask;
    logic [31:0] dut_regs [4];
    logic        wr_hs;
    logic        rd_hs;
    dut_regs[0] = reg0_out; dut_regs[1] = reg1_out;
    dut_regs[2] = reg2_out; dut_regs[3] = reg3_out;
    if (!rst_n) begin
      check("rst_awready", {31'b0, awready}, 32'd0);
      check("rst_wready",  {31'b0, wready},  32'd0);
      check("rst_bvalid",  {31'b0, bvalid},  32'd0);
      check("rst_arready", {31'b0, arready}, 32'd0);
      check("rst_rvalid",  {31'b0, rvalid},  32'd0);
      check("rst_rdata",   rdata, 32'd0);
      check("rst_pulse",   {28'b0, reg_wr_pulse}, 32'd0);
      for (int k = 0; k < 4; k++) begin
        check($sformatf("rst_reg%0d", k), dut_regs[k], 32'd0);
        m_regs[k] = '0;
      end
      m_bpend = 0; m_rpend = 0; m_rdata = '0; m_pulse = '0;
      prev_awready = 0; prev_arready = 0;
    end else begin
      // compare against the model
      for (int k = 0; k < 4; k++)
        check($sformatf("reg%0d_out", k), dut_regs[k], m_regs[k]);
      check("wr_pulse", {28'b0, reg_wr_pulse}, {28'b0, m_pulse});
      check("bvalid",   {31'b0, bvalid}, {31'b0, m_bpend});
      check("bresp",    {30'b0, bresp},  32'd0);
      check("rvalid",   {31'b0, rvalid}, {31'b0, m_rpend});
      check("rresp",    {30'b0, rresp},  32'd0);
      if (m_rpend) check("rdata", rdata, m_rdata);
      // channel rules
      check("awready_eq_wready", {31'b0, awready}, {31'b0, wready});
      if (awready) begin
        check("aw_w_both_valid", {30'b0, awvalid, wvalid}, 32'd3);
        check("no_accept_with_bvalid", {31'b0, bvalid}, 32'd0);
        check("awready_one_cycle", {31'b0, prev_awready}, 32'd0);
      end
      if (arready) begin
        check("no_accept_with_rvalid", {31'b0, rvalid}, 32'd0);
        check("arready_one_cycle", {31'b0, prev_arready}, 32'd0);
      end
      if (reg_wr_pulse != 4'b0) pulse_log.push_back(reg_wr_pulse);

      // advance the model to the state after the coming edge
      wr_hs = awready && awvalid && wvalid;
      rd_hs = arready && arvalid;
      if (m_bpend && bready) m_bpend = 0;
      if (m_rpend && rready) m_rpend = 0;
      if (rd_hs) begin
        m_rdata = m_regs[araddr[3:2]];   // read sees the pre-write value
        m_rpend = 1;
      end
      m_pulse = '0;
      if (wr_hs) begin
        mask = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
        m_regs[awaddr[3:2]] = (m_regs[awaddr[3:2]] & ~mask) | (wdata & mask);
        m_pulse = 4'b0001 << awaddr[3:2];
        m_bpend = 1;
      end
      prev_awready = awready;
      prev_arready = arready;
    end
  end

  // -------------------------------------------------------------------------
  // Ready generators for B and R (random when enabled, else left to tests)
  // -------------------------------------------------------------------------
  bit bready_rand = 0;
  bit rready_rand = 0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bready_rand) bready = ($urandom_range(0, 3) != 0);
      if (rready_rand) rready = ($urandom_range(0, 3) != 0);
    end
  end

  // -------------------------------------------------------------------------
  // Master tasks. Entered and left one time unit after a rising edge.
  // -------------------------------------------------------------------------
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int lead);
    int budget;
    if (lead >= 0) begin
      awaddr = addr; awvalid = 1;
      repeat (lead) begin @(posedge clk); #1; end
      wdata = data; wstrb = strb; wvalid = 1;
    end else begin
      wdata = data; wstrb = strb; wvalid = 1;
      repeat (-lead) begin @(posedge clk); #1; end
      awaddr = addr; awvalid = 1;
    end
    budget = 0;
    forever begin
      @(negedge clk);
      if (awready) break;
      budget++;
      if (budget > 64) begin check("aw_timeout", {31'b0, awready}, 32'd1); break; end
    end
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    budget = 0;
    forever begin
      @(negedge clk);
      if (bvalid && bready) break;
      budget++;
      if (budget > 64) begin check("b_timeout", {31'b0, bvalid}, 32'd1); break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
    int budget;
    araddr = addr; arvalid = 1;
    budget = 0;
    forever begin
      @(negedge clk);
      if (arready) break;
      budget++;
      if (budget > 64) begin check("ar_timeout", {31'b0, arready}, 32'd1); break; end
    end
    @(posedge clk); #1;
    arvalid = 0;
    budget = 0;
    data = 'x;
    forever begin
      @(negedge clk);
      if (rvalid && rready) begin data = rdata; break; end
      budget++;
      if (budget > 64) begin check("r_timeout", {31'b0, rvalid}, 32'd1); break; end
    end
    @(posedge clk); #1;
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          cnt;
    int          budget;

    rst_n = 0;
    awaddr = '0; awprot = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0;
    bready = 1; araddr = '0; arprot = '0; arvalid = 0; rready = 1;

    // ---- reset state
    repeat (3) @(negedge clk);
    check("reset_reg0", reg0_out, 32'd0);
    check("reset_bvalid", {31'b0, bvalid}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    repeat (2) begin @(posedge clk); #1; end

    // ---- sequential writes then reads, pulse order
    pulse_log.delete();
    for (int k = 0; k < 4; k++) axi_write(4'(k * 4), 32'(k + 1), 4'hF, 0);
    check("pulse_count", pulse_log.size(), 32'd4);
    for (int k = 0; k < 4 && k < pulse_log.size(); k++)
      check($sformatf("pulse_order%0d", k), {28'b0, pulse_log[k]}, 32'(1 << k));
    for (int k = 0; k < 4; k++) begin
      axi_read(4'(k * 4), rd);
      check($sformatf("seq_read%0d", k), rd, 32'(k + 1));
    end

    // ---- byte strobes
    axi_write(4'h4, 32'hFFFF_FFFF, 4'hF, 0);
    axi_write(4'h4, 32'h1234_5678, 4'b0101, 0);
    check("strobe_reg1", reg1_out, 32'hFF34_FF78);
    axi_read(4'h4, rd);
    check("strobe_read", rd, 32'hFF34_FF78);
    axi_write(4'h5, 32'hDEAD_BEEF, 4'b0000, 1);   // no lanes, offset bits ignored
    check("zero_strobe_reg1", reg1_out, 32'hFF34_FF78);

    // ---- AW leads W by three cycles
    awaddr = 4'h0; awvalid = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("aw_alone_no_ready", {30'b0, awready, wready}, 32'd0);
      @(posedge clk); #1;
    end
    wdata = 32'hCAFE_0001; wstrb = 4'hF; wvalid = 1;
    @(negedge clk);
    check("w_arrives_no_ready_yet", {30'b0, awready, wready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("aw_w_ready_together", {30'b0, awready, wready}, 32'd3);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    @(negedge clk);
    check("bvalid_next_cycle", {31'b0, bvalid}, 32'd1);
    @(posedge clk); #1;
    check("skew_reg0", reg0_out, 32'hCAFE_0001);

    // ---- B back-pressure blocks a second write
    bready = 0;
    awaddr = 4'hC; awvalid = 1; wdata = 32'h0BAD_F00D; wstrb = 4'hF; wvalid = 1;
    budget = 0;
    do begin @(negedge clk); budget++; end while (!awready && budget < 16);
    check("bp_first_ready", {31'b0, awready}, 32'd1);
    @(posedge clk); #1;
    awaddr = 4'h0; wdata = 32'h5555_AAAA;            // second write presented
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_bvalid_held", {31'b0, bvalid}, 32'd1);
      check("bp_no_second_ready", {31'b0, awready}, 32'd0);
      @(posedge clk); #1;
    end
    bready = 1;
    @(negedge clk);
    check("bp_handshake_cycle_no_ready", {31'b0, awready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_second_ready_after_b", {31'b0, awready}, 32'd1);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    @(negedge clk);
    check("bp_second_bvalid", {31'b0, bvalid}, 32'd1);
    @(posedge clk); #1;
    check("bp_reg3", reg3_out, 32'h0BAD_F00D);
    check("bp_reg0", reg0_out, 32'h5555_AAAA);

    // ---- same-edge read and write of register 2
    check("pre_same_edge_reg2", reg2_out, 32'h3);
    fork
      axi_write(4'h8, 32'hAA, 4'hF, 0);
      axi_read(4'h8, rd);
    join
    check("same_edge_read_old", rd, 32'h3);
    axi_read(4'h8, rd);
    check("same_edge_read_new", rd, 32'hAA);

    // ---- throughput with ready held high
    awaddr = 4'h4; wdata = 32'h7777_0000; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (awready) cnt++;
      @(posedge clk); #1;
    end
    awvalid = 0; wvalid = 0;
    check("write_throughput", cnt, 32'd10);
    repeat (2) begin @(posedge clk); #1; end
    araddr = 4'h4; arvalid = 1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (arready) cnt++;
      @(posedge clk); #1;
    end
    arvalid = 0;
    check("read_throughput", cnt, 32'd10);
    repeat (2) begin @(posedge clk); #1; end

    // ---- randomized mixed traffic
    bready_rand = 1; rready_rand = 1;
    for (int n = 0; n < 150; n++) begin
      logic [3:0]  w_addr, r_addr, w_strb;
      logic [31:0] w_data;
      int          lead, sel;
      w_addr = 4'($urandom_range(0, 15));
      r_addr = 4'($urandom_range(0, 15));
      w_strb = 4'($urandom_range(0, 15));
      w_data = $urandom;
      lead   = $urandom_range(0, 4) - 2;
      sel    = $urandom_range(0, 2);
      fork
        begin if (sel != 1) axi_write(w_addr, w_data, w_strb, lead); end
        begin if (sel != 0) axi_read(r_addr, rd); end
      join
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    bready_rand = 0; rready_rand = 0;
    bready = 1; rready = 1;
    repeat (2) begin @(posedge clk); #1; end

    // ---- reset with a B and an R response both outstanding
    bready = 0; rready = 0;
    awaddr = 4'h4; wdata = 32'h1357_9BDF; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    araddr = 4'hC; arvalid = 1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_mid_both_ready", {30'b0, awready, arready}, 32'd3);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    @(negedge clk);
    check("rst_mid_both_valid", {30'b0, bvalid, rvalid}, 32'd3);
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    check("rst_async_bvalid", {31'b0, bvalid}, 32'd0);
    check("rst_async_rvalid", {31'b0, rvalid}, 32'd0);
    check("rst_async_reg0", reg0_out, 32'd0);
    check("rst_async_reg1", reg1_out, 32'd0);
    check("rst_async_reg2", reg2_out, 32'd0);
    check("rst_async_reg3", reg3_out, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;
    bready = 1; rready = 1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_no_bvalid", {31'b0, bvalid}, 32'd0);
      @(posedge clk); #1;
    end
    axi_read(4'h0, rd);
    check("post_rst_read0", rd, 32'd0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
